address_bus_ws_m: RTL and testbench

Parametrised, registered successor to the combinational address decoder. It decodes the CPU address into memory-region selects plus an IO_COUNT-wide one-hot IO-register select vector. It inserts per-region wait states by deasserting cpu_rdy, and latches a sticky error on accesses to unmapped addresses. It sits between the 6502 bus and RAM/VRAM/firmware/ROM and the memory-mapped IO registers.

---
 rtl/address_bus_ws_m_pkg.sv | 20 ++
 rtl/address_bus_ws_m_if.sv | 44 ++++
 rtl/address_bus_ws_m_wait_counter.sv | 27 ++
 rtl/address_bus_ws_m.sv | 159 +++++++++++++++
 tb/tb_address_bus_ws_m.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/address_bus_ws_m_pkg.sv
// Shared types and default constants for the registered address decoder.
package address_bus_pkg;

  typedef enum logic [2:0] {REGION_NONE, RAM, VRAM, FW, IO, ROM} region_e;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  localparam int unsigned WAIT_W = 4;

  localparam int unsigned DEF_ADDR_W    = 16;
  localparam int unsigned DEF_RAM_END   = 'h36ff;
  localparam int unsigned DEF_VRAM_END  = 'h3fff;
  localparam int unsigned DEF_FW_END    = 'h6fff;
  localparam int unsigned DEF_IO_BASE   = 'h7000;
  localparam int unsigned DEF_IO_COUNT  = 4;
  localparam int unsigned DEF_ROM_BASE  = 'h8000;
  localparam int unsigned DEF_VRAM_WAIT = 0;
  localparam int unsigned DEF_FW_WAIT   = 1;
  localparam int unsigned DEF_ROM_WAIT  = 2;

endpackage

// File: rtl/address_bus_ws_m_if.sv
// CPU-side bus bundle for address_bus_ws_m; watch signals exist only with ADDRESS_BUS_WS_WATCH_EN.
interface address_bus_ws_m_if #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned IO_COUNT = 4
) ();
  logic [ADDR_W-1:0]   cpu_address;
  logic                cpu_valid;
  logic                err_clr;
  logic                cpu_rdy;
  logic                SELECT_ram;
  logic                SELECT_vram;
  logic                SELECT_firmware;
  logic                SELECT_rom;
  logic [IO_COUNT-1:0] SELECT_io;
  logic                unmapped_err;
  logic [ADDR_W-1:0]   err_addr;
`ifdef ADDRESS_BUS_WS_WATCH_EN
  logic [ADDR_W-1:0]   watch_addr;
  logic                watch_arm;
  logic                watch_hit;

  modport master (
    output cpu_address, cpu_valid, err_clr, watch_addr, watch_arm,
    input  cpu_rdy, SELECT_ram, SELECT_vram, SELECT_firmware, SELECT_rom,
           SELECT_io, unmapped_err, err_addr, watch_hit
  );
  modport slave (
    input  cpu_address, cpu_valid, err_clr, watch_addr, watch_arm,
    output cpu_rdy, SELECT_ram, SELECT_vram, SELECT_firmware, SELECT_rom,
           SELECT_io, unmapped_err, err_addr, watch_hit
  );
`else
  modport master (
    output cpu_address, cpu_valid, err_clr,
    input  cpu_rdy, SELECT_ram, SELECT_vram, SELECT_firmware, SELECT_rom,
           SELECT_io, unmapped_err, err_addr
  );
  modport slave (
    input  cpu_address, cpu_valid, err_clr,
    output cpu_rdy, SELECT_ram, SELECT_vram, SELECT_firmware, SELECT_rom,
           SELECT_io, unmapped_err, err_addr
  );
`endif
endinterface

// File: rtl/address_bus_ws_m_wait_counter.sv
// Loadable wait-state down-counter; o_done flags the last wait cycle.
module wait_counter_m
  import address_bus_pkg::*;
#(
  parameter int unsigned W = WAIT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_dec,
  output logic         o_done
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == W'(1));
endmodule

// File: rtl/address_bus_ws_m.sv
// Registered address decoder with per-region wait states and sticky unmapped-access error.
// Optional address watchpoint under ADDRESS_BUS_WS_WATCH_EN.
module address_bus_ws_m
  import address_bus_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned RAM_END   = DEF_RAM_END,
  parameter int unsigned VRAM_END  = DEF_VRAM_END,
  parameter int unsigned FW_END    = DEF_FW_END,
  parameter int unsigned IO_BASE   = DEF_IO_BASE,
  parameter int unsigned IO_COUNT  = DEF_IO_COUNT,
  parameter int unsigned ROM_BASE  = DEF_ROM_BASE,
  parameter int unsigned VRAM_WAIT = DEF_VRAM_WAIT,
  parameter int unsigned FW_WAIT   = DEF_FW_WAIT,
  parameter int unsigned ROM_WAIT  = DEF_ROM_WAIT
) (
  input logic           clk,
  input logic           rst_n,
  address_bus_ws_m_if.slave bus
);
  if (IO_BASE + IO_COUNT > ROM_BASE) begin : g_chk_io
    $error("IO window overlaps ROM");
  end
  if (FW_END >= IO_BASE) begin : g_chk_fw
    $error("firmware region overlaps IO window");
  end
  if ((VRAM_WAIT >= 2**WAIT_W) || (FW_WAIT >= 2**WAIT_W) || (ROM_WAIT >= 2**WAIT_W)) begin : g_chk_wait
    $error("wait count exceeds counter width");
  end

  localparam logic [ADDR_W-1:0] L_RAM_END  = ADDR_W'(RAM_END);
  localparam logic [ADDR_W-1:0] L_VRAM_END = ADDR_W'(VRAM_END);
  localparam logic [ADDR_W-1:0] L_FW_END   = ADDR_W'(FW_END);
  localparam logic [ADDR_W-1:0] L_IO_BASE  = ADDR_W'(IO_BASE);
  localparam logic [ADDR_W:0]   L_IO_LIM   = (ADDR_W+1)'(IO_BASE + IO_COUNT);
  localparam logic [ADDR_W-1:0] L_ROM_BASE = ADDR_W'(ROM_BASE);

  state_e              r_state, w_next;
  region_e             w_region;
  logic [IO_COUNT-1:0] w_io;
  logic [ADDR_W-1:0]   w_io_off;
  logic [WAIT_W-1:0]   w_wait;
  logic                w_rdy, w_accept, w_load, w_cnt_done;

  logic                r_ram, r_vram, r_fw, r_rom;
  logic [IO_COUNT-1:0] r_io;
  logic                r_err;
  logic [ADDR_W-1:0]   r_err_addr;

  assign w_io_off = bus.cpu_address - L_IO_BASE;

  always_comb begin
    w_region = REGION_NONE;
    w_io     = '0;
    if (bus.cpu_address <= L_RAM_END) begin
      w_region = RAM;
    end else if (bus.cpu_address <= L_VRAM_END) begin
      w_region = VRAM;
    end else if (bus.cpu_address <= L_FW_END) begin
      w_region = FW;
    end else if ((bus.cpu_address >= L_IO_BASE) && ({1'b0, bus.cpu_address} < L_IO_LIM)) begin
      w_region = IO;
      w_io     = IO_COUNT'(1) << w_io_off;
    end else if (bus.cpu_address >= L_ROM_BASE) begin
      w_region = ROM;
    end
  end

  always_comb begin
    w_wait = '0;
    case (w_region)
      VRAM:    w_wait = WAIT_W'(VRAM_WAIT);
      FW:      w_wait = WAIT_W'(FW_WAIT);
      ROM:     w_wait = WAIT_W'(ROM_WAIT);
      default: w_wait = '0;
    endcase
  end

  always_comb begin
    w_next   = r_state;
    w_rdy    = 1'b1;
    w_accept = 1'b0;
    w_load   = 1'b0;
    unique case (r_state)
      IDLE, DONE: begin
        w_accept = bus.cpu_valid;
        w_load   = bus.cpu_valid && (w_wait != '0);
        w_next   = w_load ? WAIT : IDLE;
      end
      WAIT: begin
        w_rdy = 1'b0;
        if (w_cnt_done) w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  wait_counter_m #(.W(WAIT_W)) u_wait_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_val  (w_wait),
    .i_dec  (r_state == WAIT),
    .o_done (w_cnt_done)
  );

  // Selects hold through WAIT; with rdy high they follow each accepted access or clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_ram, r_vram, r_fw, r_rom} <= '0;
      r_io                         <= '0;
    end else if (w_accept) begin
      r_ram  <= (w_region == RAM);
      r_vram <= (w_region == VRAM);
      r_fw   <= (w_region == FW);
      r_rom  <= (w_region == ROM);
      r_io   <= w_io;
    end else if (w_rdy) begin
      {r_ram, r_vram, r_fw, r_rom} <= '0;
      r_io                         <= '0;
    end
  end

  // A new unmapped access takes priority over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else if (w_accept && (w_region == REGION_NONE)) begin
      r_err      <= 1'b1;
      r_err_addr <= bus.cpu_address;
    end else if (bus.err_clr) begin
      r_err      <= 1'b0;
    end
  end

`ifdef ADDRESS_BUS_WS_WATCH_EN
  logic r_watch_hit;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_watch_hit <= 1'b0;
    else        r_watch_hit <= w_accept && bus.watch_arm && (bus.cpu_address == bus.watch_addr);
  end
  assign bus.watch_hit = r_watch_hit;
`endif

  assign bus.cpu_rdy         = w_rdy;
  assign bus.SELECT_ram      = r_ram;
  assign bus.SELECT_vram     = r_vram;
  assign bus.SELECT_firmware = r_fw;
  assign bus.SELECT_rom      = r_rom;
  assign bus.SELECT_io       = r_io;
  assign bus.unmapped_err    = r_err;
  assign bus.err_addr        = r_err_addr;
endmodule

// File: tb/tb_address_bus_ws_m.sv
// Randomized bench for address_bus_ws_m against a cycle-count reference model.
module tb_address_bus_ws_m;
  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 0;

  address_bus_ws_m_if #(.ADDR_W(16), .IO_COUNT(4)) bus ();

  address_bus_ws_m #(
    .ADDR_W(16), .RAM_END('h36ff), .VRAM_END('h3fff), .FW_END('h6fff),
    .IO_BASE('h7000), .IO_COUNT(4), .ROM_BASE('h8000),
    .VRAM_WAIT(0), .FW_WAIT(1), .ROM_WAIT(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected select word layout: {ram, vram, fw, rom, io[3:0]}.
  function automatic logic [7:0] ref_sel(input logic [15:0] a);
    int unsigned v = a;
    if (v <= 'h36ff)                 return 8'b1000_0000;
    if (v <= 'h3fff)                 return 8'b0100_0000;
    if (v <= 'h6fff)                 return 8'b0010_0000;
    if (v >= 'h7000 && v <= 'h7003)  return 8'(1 << (v - 'h7000));
    if (v >= 'h8000)                 return 8'b0001_0000;
    return 8'h00;
  endfunction

  function automatic int ref_wait(input logic [15:0] a);
    int unsigned v = a;
    if (v >= 'h3700 && v <= 'h3fff) return 0;
    if (v >= 'h4000 && v <= 'h6fff) return 1;
    if (v >= 'h8000)                return 2;
    return 0;
  endfunction

  function automatic logic [7:0] dut_sel();
    return {bus.SELECT_ram, bus.SELECT_vram, bus.SELECT_firmware, bus.SELECT_rom, bus.SELECT_io};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: stall cycles remaining after an accepted access.
  int          m_stall = 0;
  logic [7:0]  m_sel   = '0;
  logic        m_err   = 1'b0;
  logic [15:0] m_eaddr = '0;
  logic        m_hit   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stall = 0; m_sel = '0; m_err = 1'b0; m_eaddr = '0; m_hit = 1'b0;
    end else begin
      logic acc;
      acc   = (m_stall == 0) && bus.cpu_valid;
      m_hit = 1'b0;
      if (acc) begin
        m_sel   = ref_sel(bus.cpu_address);
        m_stall = ref_wait(bus.cpu_address);
`ifdef ADDRESS_BUS_WS_WATCH_EN
        m_hit   = bus.watch_arm && (bus.cpu_address == bus.watch_addr);
`endif
      end else if (m_stall == 0) begin
        m_sel = '0;
      end else begin
        m_stall = m_stall - 1;
      end
      if (acc && ref_sel(bus.cpu_address) == 8'h00) begin
        m_err = 1'b1; m_eaddr = bus.cpu_address;
      end else if (bus.err_clr) begin
        m_err = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_rdy",      {31'b0, bus.cpu_rdy},      {31'b0, (m_stall == 0)});
      chk("m_sel",      {24'b0, dut_sel()},        {24'b0, m_sel});
      chk("m_err",      {31'b0, bus.unmapped_err}, {31'b0, m_err});
      chk("m_err_addr", {16'b0, bus.err_addr},     {16'b0, m_eaddr});
`ifdef ADDRESS_BUS_WS_WATCH_EN
      chk("m_hit",      {31'b0, bus.watch_hit},    {31'b0, m_hit});
`endif
    end
  end

  task automatic drive(input logic v, input logic [15:0] a, input logic c);
    bus.cpu_valid   = v;
    bus.cpu_address = a;
    bus.err_clr     = c;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 15))
      0:  return 16'h0000;
      1:  return 16'h36ff;
      2:  return 16'h3700;
      3:  return 16'h3fff;
      4:  return 16'h4000;
      5:  return 16'h6fff;
      6:  return 16'(16'h7000 + $urandom_range(0, 4));
      7:  return 16'h7fff;
      8:  return 16'h8000;
      9:  return 16'hffff;
      10: return 16'(16'h7000 + $urandom_range(0, 'hfff));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    rst_n           = 1'b0;
    bus.cpu_valid   = 1'b0;
    bus.cpu_address = '0;
    bus.err_clr     = 1'b0;
`ifdef ADDRESS_BUS_WS_WATCH_EN
    bus.watch_addr  = '0;
    bus.watch_arm   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy",  {31'b0, bus.cpu_rdy},      32'd1);
    chk("rst_sel",  {24'b0, dut_sel()},        32'd0);
    chk("rst_err",  {31'b0, bus.unmapped_err}, 32'd0);
    chk("rst_eadr", {16'b0, bus.err_addr},     32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    drive(1'b1, 16'h0000, 1'b0);
    chk("ram0_sel", {24'b0, dut_sel()}, 32'h80);
    chk("ram0_rdy", {31'b0, bus.cpu_rdy}, 32'd1);
    drive(1'b1, 16'h36ff, 1'b0);
    chk("ram_end_sel", {24'b0, dut_sel()}, 32'h80);
    drive(1'b1, 16'h3700, 1'b0);
    chk("vram_sel", {24'b0, dut_sel()}, 32'h40);
    chk("vram_rdy", {31'b0, bus.cpu_rdy}, 32'd1);
    drive(1'b0, 16'h0000, 1'b0);
    chk("idle_sel", {24'b0, dut_sel()}, 32'h00);

    drive(1'b1, 16'h8000, 1'b0);
    chk("rom_w1_sel", {24'b0, dut_sel()}, 32'h10);
    chk("rom_w1_rdy", {31'b0, bus.cpu_rdy}, 32'd0);
    drive(1'b1, 16'h0000, 1'b0);
    chk("rom_w2_sel", {24'b0, dut_sel()}, 32'h10);
    chk("rom_w2_rdy", {31'b0, bus.cpu_rdy}, 32'd0);
    drive(1'b1, 16'h0000, 1'b0);
    chk("rom_done_sel", {24'b0, dut_sel()}, 32'h10);
    chk("rom_done_rdy", {31'b0, bus.cpu_rdy}, 32'd1);
    drive(1'b0, 16'h0000, 1'b0);
    chk("rom_after_sel", {24'b0, dut_sel()}, 32'h00);

    for (int unsigned k = 0; k < 4; k++) begin
      drive(1'b1, 16'(16'h7000 + k), 1'b0);
      chk("io_onehot", {24'b0, dut_sel()}, 32'(1 << k));
    end

    drive(1'b1, 16'h7004, 1'b0);
    chk("unm_sel",  {24'b0, dut_sel()},        32'h00);
    chk("unm_err",  {31'b0, bus.unmapped_err}, 32'd1);
    chk("unm_addr", {16'b0, bus.err_addr},     32'h7004);
    chk("unm_rdy",  {31'b0, bus.cpu_rdy},      32'd1);
    drive(1'b1, 16'h7fff, 1'b1);
    chk("setwin_err",  {31'b0, bus.unmapped_err}, 32'd1);
    chk("setwin_addr", {16'b0, bus.err_addr},     32'h7fff);
    drive(1'b0, 16'h0000, 1'b1);
    chk("clr_err",  {31'b0, bus.unmapped_err}, 32'd0);
    chk("clr_addr", {16'b0, bus.err_addr},     32'h7fff);

    drive(1'b1, 16'h4000, 1'b0);
    chk("fw_sel", {24'b0, dut_sel()}, 32'h20);
    chk("fw_rdy", {31'b0, bus.cpu_rdy}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rdy", {31'b0, bus.cpu_rdy}, 32'd1);
    chk("midrst_sel", {24'b0, dut_sel()},   32'h00);
    bus.cpu_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

`ifdef ADDRESS_BUS_WS_WATCH_EN
    bus.watch_addr = 16'h7001;
    bus.watch_arm  = 1'b1;
    drive(1'b1, 16'h7001, 1'b0);
    chk("watch_hit",   {31'b0, bus.watch_hit}, 32'd1);
    drive(1'b0, 16'h7001, 1'b0);
    chk("watch_pulse", {31'b0, bus.watch_hit}, 32'd0);
    bus.watch_arm = 1'b0;
    drive(1'b1, 16'h7001, 1'b0);
    chk("watch_disarm", {31'b0, bus.watch_hit}, 32'd0);
`endif

    for (int i = 0; i < 3000; i++) begin
`ifdef ADDRESS_BUS_WS_WATCH_EN
      bus.watch_arm  = 1'($urandom_range(0, 1));
      bus.watch_addr = ($urandom_range(0, 1) == 1) ? pick_addr() : bus.watch_addr;
`endif
      drive(1'($urandom_range(0, 3) != 0), pick_addr(), 1'($urandom_range(0, 7) == 0));
    end

    drive(1'b0, 16'h0000, 1'b0);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
